spi_cmd_rx: RTL and testbench
=============================

// Module: spi_cmd_rx
// PURPOSE
//  SPI slave (mode 0: CPOL=0, CPHA=0) receiving voice tuning commands from the host MCU.
//  Decodes each 40-bit frame into a one-cycle command pulse on SPI_flag, SPI_voice_index and SPI_tuning_code.
//  These outputs drive the dds block's i_SPI_* ports directly.
//  Replaces the internal counter-driven command generator used on the debug top.
// PARAMETERS
//  NUM_VOICES    256  voices accepted; a frame with voice index >= NUM_VOICES is rejected
//  FRAME_BITS    40   bits per frame: 8-bit voice index, then 32-bit tuning code, MSB first
// PORTS
//  ref_clk            in   1   system clock; all logic is synchronous to it
//  reset              in   1   synchronous, active-high
//  spi_sclk           in   1   SPI clock from MCU, asynchronous to ref_clk
//  spi_cs_n           in   1   chip select, active-low, asynchronous
//  spi_mosi           in   1   serial data, asynchronous
//  o_SPI_flag         out  1   one-cycle pulse: new command valid
//  o_SPI_voice_index  out  8   voice index of the last accepted frame
//  o_SPI_tuning_code  out  32  phase increment of the last accepted frame
//  o_frame_err        out  1   one-cycle pulse: frame rejected
//  o_err_count        out  8   saturating count of rejected frames
// BEHAVIOUR
//  - Reset values: o_SPI_flag=0, o_SPI_voice_index=0, o_SPI_tuning_code=0, o_frame_err=0, o_err_count=0.
//  - Input sync: each of sclk, cs_n and mosi passes through 2 flops.
//    - Sync flops reset to sclk=0, cs_n=1, mosi=0.
//    - Edges are detected against a third delayed copy.
//  - Timing limit: SCLK <= ref_clk/8. Minimum cs_n high time between frames is 4 ref_clk.
//  - FSM states: WAIT_IDLE, IDLE, SHIFT, OVERRUN. Reset state is WAIT_IDLE.
//    - WAIT_IDLE -> IDLE when synced cs_n=1. This prevents a frame that started before reset from being accepted.
//    - IDLE -> SHIFT on synced cs_n=0. The 40-bit shift register and the 6-bit bit counter clear.
//    - SHIFT, synced sclk rising edge: shift in mosi at the LSB and increment the counter.
//      On the 41st edge, go to OVERRUN.
//    - SHIFT, synced cs_n rising edge:
//      - Count==40 and index<NUM_VOICES: commit the frame.
//      - Otherwise: error.
//      - In both cases -> IDLE.
//    - OVERRUN: ignore sclk. On cs_n rise, error -> IDLE.
//  - Commit:
//    - o_SPI_voice_index <= sr[39:32] and o_SPI_tuning_code <= sr[31:0].
//    - o_SPI_flag=1 for exactly one cycle in the same cycle the data registers update.
//    - Data outputs hold until the next commit.
//  - Error: o_frame_err=1 for one cycle. o_err_count increments and saturates at 255. Data outputs are unchanged.
//  - Latency: o_SPI_flag rises on the 4th ref_clk edge after cs_n is first sampled high at the pin.
//    Breakdown: 2 sync flops + 1 edge-detect flop + 1 output register.
//  - sclk and cs_n edges in the same cycle: process the sclk edge first (shift), then evaluate cs_n with the updated count.
//  - A zero-length frame (cs_n pulse with no sclk) is an error.
//  - Reset mid-frame: discard the partial frame, clear all outputs, go to WAIT_IDLE.
//  - Asserting o_SPI_flag twice within 4 cycles is impossible by construction.
// STRUCTURE
//  - Shared package (synth_pkg):
//    - SPI_FRAME_BITS=40, VOICE_IDX_W=8, TUNING_W=32
//    - FSM state encoding localparams for spi_cmd_rx
//  - Sub-module sync_2ff (parameterised width, configurable reset value):
//    - Instantiated once for the 3-bit {sclk, cs_n, mosi} bundle.
//    - Reused later for MIDI UART rx.
//  - Shift register, counter and FSM stay in spi_cmd_rx.
// TESTING
//  1. Frame index 0x05, code 0x000F4240, SCLK=ref_clk/8:
//     -> single o_SPI_flag pulse 4 clk after cs_n rise; index=5, code=1000000; err_count=0.
//  2. Frame of 39 bits:
//     -> no flag; o_frame_err pulse; err_count=1; data outputs keep their previous values.
//  3. Frame of 41 bits:
//     -> OVERRUN; no flag; err pulse on cs_n rise; err_count increments.
//  4. NUM_VOICES=128, valid-length frame with index 0x80:
//     -> rejected with err pulse. Same frame with index 0x7F -> accepted.
//  5. Two valid frames back-to-back with 4-clk cs_n gap (idx 1 code 0xAAAA5555, then idx 2 code 0x12345678):
//     -> two flags, in order, with correct data.
//  6. Reset asserted after bit 20 with cs_n still low, then frame completes:
//     -> no flag and no error. A following clean frame is accepted normally.
//  Also check: 300 bad frames -> err_count saturates at 255.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the synth datapath blocks.
//   - SPI command frame geometry (voice index + tuning code).
//   - Bit positions and reset value of the synchronised SPI pin bundle.
//   - State encoding for the spi_cmd_rx receive FSM.
package synth_pkg;

    localparam int SPI_FRAME_BITS = 40;
    localparam int VOICE_IDX_W    = 8;
    localparam int TUNING_W       = 32;

    // The SPI pins travel through the synchroniser as one {sclk, cs_n, mosi} bundle.
    localparam int         SPI_SYNC_W     = 3;
    localparam int         SPI_SCLK_BIT   = 2;
    localparam int         SPI_CS_BIT     = 1;
    localparam int         SPI_MOSI_BIT   = 0;
    // Idle bus: sclk low, chip select deasserted, mosi low.
    localparam logic [2:0] SPI_SYNC_RESET = 3'b010;

    typedef enum logic [1:0] {
        SPI_WAIT_IDLE = 2'd0,
        SPI_IDLE      = 2'd1,
        SPI_SHIFT     = 2'd2,
        SPI_OVERRUN   = 2'd3
    } spi_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bundle of asynchronous inputs.
// Each bit is synchronised independently; bundle bits are not coherent with each other.
// Ports:
//   ref_clk  in   1      destination clock
//   reset    in   1      synchronous, active-high; loads RESET_VAL into both stages
//   d        in   WIDTH  asynchronous inputs
//   q        out  WIDTH  synchronised outputs (2 ref_clk of latency)
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             ref_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI slave (mode 0) receiving voice tuning commands from the host MCU.
// Each frame is FRAME_BITS long, MSB first: voice index, then tuning code.
// A correctly sized frame with an in-range voice index produces a one-cycle
// o_SPI_flag together with updated data outputs; anything else produces a
// one-cycle o_frame_err and bumps a saturating error counter.
// Ports:
//   ref_clk            in   1   system clock
//   reset              in   1   synchronous, active-high
//   spi_sclk           in   1   SPI clock, asynchronous
//   spi_cs_n           in   1   chip select, active-low, asynchronous
//   spi_mosi           in   1   serial data, asynchronous
//   o_SPI_flag         out  1   one-cycle pulse: new command valid
//   o_SPI_voice_index  out  8   voice index of the last accepted frame
//   o_SPI_tuning_code  out  32  tuning code of the last accepted frame
//   o_frame_err        out  1   one-cycle pulse: frame rejected
//   o_err_count        out  8   saturating count of rejected frames
module spi_cmd_rx
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 256,
    parameter int FRAME_BITS = SPI_FRAME_BITS
) (
    input  logic                   ref_clk,
    input  logic                   reset,
    input  logic                   spi_sclk,
    input  logic                   spi_cs_n,
    input  logic                   spi_mosi,
    output logic                   o_SPI_flag,
    output logic [VOICE_IDX_W-1:0] o_SPI_voice_index,
    output logic [TUNING_W-1:0]    o_SPI_tuning_code,
    output logic                   o_frame_err,
    output logic [7:0]             o_err_count
);

    // Counter must be able to represent one edge past a full frame.
    localparam int                   CNT_W       = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0]     CNT_FULL    = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]     CNT_OVER    = CNT_W'(FRAME_BITS + 1);
    localparam logic [VOICE_IDX_W:0] VOICE_LIMIT = (VOICE_IDX_W + 1)'(NUM_VOICES);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ---- stage p0/p1: two-flop synchroniser ----
    logic [SPI_SYNC_W-1:0] pins_s;

    sync_2ff #(
        .WIDTH     (SPI_SYNC_W),
        .RESET_VAL (SPI_SYNC_RESET)
    ) u_sync (
        .ref_clk (ref_clk),
        .reset   (reset),
        .d       ({spi_sclk, spi_cs_n, spi_mosi}),
        .q       (pins_s)
    );

    // ---- stage p2: delayed copy and registered edge detect ----
    logic sclk_d;
    logic cs_n_d;
    logic sclk_rise;
    logic cs_rise;
    logic mosi_bit;

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            sclk_d    <= 1'b0;
            cs_n_d    <= 1'b1;
            sclk_rise <= 1'b0;
            cs_rise   <= 1'b0;
            mosi_bit  <= 1'b0;
        end else begin
            sclk_d    <= pins_s[SPI_SCLK_BIT];
            cs_n_d    <= pins_s[SPI_CS_BIT];
            sclk_rise <= pins_s[SPI_SCLK_BIT] & ~sclk_d;
            cs_rise   <= pins_s[SPI_CS_BIT] & ~cs_n_d;
            // mosi is delayed alongside the edge so it is the value present at the sclk rise.
            mosi_bit  <= pins_s[SPI_MOSI_BIT];
        end
    end

    // ---- stage p3: shift register, counter, FSM and output registers ----
    spi_rx_state_t         state;
    logic [1:0]            settle;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]      cnt_next;
    logic [FRAME_BITS-1:0] sr_next;
    logic                  frame_ok;

    // An sclk edge coinciding with the cs_n rise is shifted in before the
    // frame is judged, so the decision always uses the updated count/data.
    always_comb begin
        cnt_next = bit_cnt;
        sr_next  = shift_reg;
        if (sclk_rise) begin
            cnt_next = bit_cnt + CNT_W'(1);
            if (bit_cnt != CNT_FULL) begin
                sr_next = {shift_reg[FRAME_BITS-2:0], mosi_bit};
            end
        end
        frame_ok = (cnt_next == CNT_FULL) &&
                   ({1'b0, sr_next[FRAME_BITS-1 -: VOICE_IDX_W]} < VOICE_LIMIT);
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state             <= SPI_WAIT_IDLE;
            settle            <= 2'd0;
            o_SPI_flag        <= 1'b0;
            o_SPI_voice_index <= '0;
            o_SPI_tuning_code <= '0;
            o_frame_err       <= 1'b0;
            o_err_count       <= 8'd0;
        end else begin
            o_SPI_flag  <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                // The synchroniser and delay flops still hold reset values for
                // three cycles; only after they have been refilled from the pin
                // does a high cs_n mean the bus is really idle. Without this a
                // frame already in flight at reset would look like a fresh one.
                SPI_WAIT_IDLE: begin
                    if (settle != 2'd3) begin
                        settle <= settle + 2'd1;
                    end else if (pins_s[SPI_CS_BIT] && cs_n_d) begin
                        state <= SPI_IDLE;
                    end
                end
                SPI_IDLE: begin
                    if (!pins_s[SPI_CS_BIT]) begin
                        state     <= SPI_SHIFT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end
                SPI_SHIFT: begin
                    bit_cnt   <= cnt_next;
                    shift_reg <= sr_next;
                    if (cs_rise) begin
                        state <= SPI_IDLE;
                        if (frame_ok) begin
                            o_SPI_flag        <= 1'b1;
                            o_SPI_voice_index <= sr_next[FRAME_BITS-1 -: VOICE_IDX_W];
                            o_SPI_tuning_code <= sr_next[TUNING_W-1:0];
                        end else begin
                            o_frame_err <= 1'b1;
                            o_err_count <= sat_inc(o_err_count);
                        end
                    end else if (cnt_next == CNT_OVER) begin
                        state <= SPI_OVERRUN;
                    end
                end
                SPI_OVERRUN: begin
                    if (cs_rise) begin
                        state       <= SPI_IDLE;
                        o_frame_err <= 1'b1;
                        o_err_count <= sat_inc(o_err_count);
                    end
                end
                default: state <= SPI_WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Self-checking bench for spi_cmd_rx (instantiated with NUM_VOICES=128).
// A frame-level model predicts, for every completed frame, whether it is
// accepted or rejected and on which cycle the result appears; a compare
// process checks all outputs against that model on every cycle.
module tb_spi_cmd_rx;

    localparam int NV = 128;

    logic        ref_clk  = 1'b0;
    logic        reset    = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        o_SPI_flag;
    logic [7:0]  o_SPI_voice_index;
    logic [31:0] o_SPI_tuning_code;
    logic        o_frame_err;
    logic [7:0]  o_err_count;

    spi_cmd_rx #(.NUM_VOICES(NV)) dut (
        .ref_clk           (ref_clk),
        .reset             (reset),
        .spi_sclk          (spi_sclk),
        .spi_cs_n          (spi_cs_n),
        .spi_mosi          (spi_mosi),
        .o_SPI_flag        (o_SPI_flag),
        .o_SPI_voice_index (o_SPI_voice_index),
        .o_SPI_tuning_code (o_SPI_tuning_code),
        .o_frame_err       (o_frame_err),
        .o_err_count       (o_err_count)
    );

    always #5 ref_clk = ~ref_clk;

    int cyc = 0;
    always @(posedge ref_clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          ok;
        logic [7:0]  idx;
        logic [31:0] code;
    } ev_t;

    ev_t         evq[$];
    logic [7:0]  m_idx  = 8'd0;
    logic [31:0] m_code = 32'd0;
    int          m_errs = 0;
    int          n_vec  = 0;
    int          n_bad  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level rule: exactly 40 bits and an in-range voice index is accepted.
    function automatic ev_t outcome(input int nbits, input logic [63:0] bits, input int due);
        ev_t e;
        e.due  = due;
        e.idx  = bits[39:32];
        e.code = bits[31:0];
        e.ok   = (nbits == 40) && (int'(bits[39:32]) < NV);
        return e;
    endfunction

    // Compare process: applies any result due this cycle to the model, then checks.
    ev_t cur;
    bit  exp_flag, exp_err;
    always @(negedge ref_clk) begin
        if (!reset) begin
            exp_flag = 1'b0;
            exp_err  = 1'b0;
            if (evq.size() > 0 && evq[0].due == cyc) begin
                cur = evq.pop_front();
                if (cur.ok) begin
                    exp_flag = 1'b1;
                    m_idx    = cur.idx;
                    m_code   = cur.code;
                end else begin
                    exp_err = 1'b1;
                    if (m_errs < 255) m_errs++;
                end
            end
            chk("flag",      64'(o_SPI_flag),        64'(exp_flag));
            chk("frame_err", 64'(o_frame_err),       64'(exp_err));
            chk("voice_idx", 64'(o_SPI_voice_index), 64'(m_idx));
            chk("tuning",    64'(o_SPI_tuning_code), 64'(m_code));
            chk("err_count", 64'(o_err_count),       64'(m_errs));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge ref_clk);
    endtask

    // Sends one frame at SCLK = ref_clk/8; bits[nbits-1] goes out first.
    // rst_after >= 1 pulses reset after that many bits while cs_n stays low.
    task automatic spi_frame(input int nbits, input logic [63:0] bits, input int rst_after);
        bit aborted = 1'b0;
        spi_cs_n = 1'b0;
        idle(4);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = bits[nbits-1-i];
            idle(4);
            spi_sclk = 1'b1;
            idle(4);
            spi_sclk = 1'b0;
            if (i + 1 == rst_after) begin
                reset = 1'b1;
                idle(2);
                evq.delete();
                m_idx   = 8'd0;
                m_code  = 32'd0;
                m_errs  = 0;
                reset   = 1'b0;
                aborted = 1'b1;
            end
        end
        idle(4);
        spi_cs_n = 1'b1;
        // Result lands on the 4th ref_clk edge after cs_n goes high.
        if (!aborted) evq.push_back(outcome(nbits, bits, cyc + 4));
    endtask

    initial begin
        idle(3);
        chk("rst_flag",  64'(o_SPI_flag),        64'd0);
        chk("rst_err",   64'(o_frame_err),       64'd0);
        chk("rst_idx",   64'(o_SPI_voice_index), 64'd0);
        chk("rst_code",  64'(o_SPI_tuning_code), 64'd0);
        chk("rst_count", 64'(o_err_count),       64'd0);
        reset = 1'b0;
        idle(8);

        // Basic frame and latency
        spi_frame(40, {24'd0, 8'h05, 32'h000F4240}, -1);
        idle(3);
        chk("t1_flag_early", 64'(o_SPI_flag), 64'd0);
        idle(1);
        chk("t1_flag",  64'(o_SPI_flag),        64'd1);
        chk("t1_idx",   64'(o_SPI_voice_index), 64'd5);
        chk("t1_code",  64'(o_SPI_tuning_code), 64'd1000000);
        chk("t1_count", 64'(o_err_count),       64'd0);
        idle(1);
        chk("t1_flag_once", 64'(o_SPI_flag), 64'd0);
        idle(4);

        // Short frame
        spi_frame(39, 64'h12_3456_789A, -1);
        idle(6);
        chk("t2_count", 64'(o_err_count),       64'd1);
        chk("t2_idx",   64'(o_SPI_voice_index), 64'd5);
        chk("t2_code",  64'(o_SPI_tuning_code), 64'h000F4240);

        // Long frame (overrun)
        spi_frame(41, 64'h1FF_FFFF_FFFF, -1);
        idle(6);
        chk("t3_count", 64'(o_err_count), 64'd2);

        // Voice index range boundary
        spi_frame(40, {24'd0, 8'h80, 32'hDEADBEEF}, -1);
        idle(6);
        chk("t4_reject_count", 64'(o_err_count),       64'd3);
        chk("t4_reject_idx",   64'(o_SPI_voice_index), 64'd5);
        spi_frame(40, {24'd0, 8'h7F, 32'hCAFEF00D}, -1);
        idle(6);
        chk("t4_accept_idx",  64'(o_SPI_voice_index), 64'h7F);
        chk("t4_accept_code", 64'(o_SPI_tuning_code), 64'hCAFEF00D);

        // Back-to-back frames with minimum cs_n gap
        spi_frame(40, {24'd0, 8'h01, 32'hAAAA5555}, -1);
        idle(4);
        spi_frame(40, {24'd0, 8'h02, 32'h12345678}, -1);
        idle(6);
        chk("t5_idx",  64'(o_SPI_voice_index), 64'd2);
        chk("t5_code", 64'(o_SPI_tuning_code), 64'h12345678);

        // Reset in the middle of a frame, then a clean frame
        spi_frame(40, {24'd0, 8'h03, 32'h0BADF00D}, 20);
        idle(6);
        chk("t6_count", 64'(o_err_count),       64'd0);
        chk("t6_idx",   64'(o_SPI_voice_index), 64'd0);
        spi_frame(40, {24'd0, 8'h04, 32'h00C0FFEE}, -1);
        idle(6);
        chk("t6_clean_idx",  64'(o_SPI_voice_index), 64'd4);
        chk("t6_clean_code", 64'(o_SPI_tuning_code), 64'h00C0FFEE);

        // Randomised frames: mostly valid length, some bad lengths, half the index range rejected
        for (int f = 0; f < 40; f++) begin
            int          sel;
            int          nb;
            logic [63:0] b;
            sel = int'($urandom_range(0, 9));
            b   = {$urandom, $urandom};
            if (sel < 6)       nb = 40;
            else if (sel == 6) nb = 39;
            else if (sel == 7) nb = 41;
            else if (sel == 8) nb = 0;
            else               nb = int'($urandom_range(1, 45));
            spi_frame(nb, b, -1);
            idle(int'($urandom_range(4, 10)));
        end

        // Error counter saturation
        for (int f = 0; f < 300; f++) begin
            spi_frame(0, 64'd0, -1);
            idle(4);
        end
        idle(6);
        chk("sat_count", 64'(o_err_count), 64'd255);

        idle(10);
        chk("pending_results", 64'(evq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
